// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two requester channels, the ALU drive/return path and the
// response channel that connect to alu_share_arbiter.
//   slave  : view used by the arbiter
//   master : view used by the surrounding datapath (requesters, ALU, consumer)
// Parameter: DATA_W operand/result width.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CTRL_W = 4;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The granted request's operands/control drive the ALU; result and zero flag
// are captured into a one-entry response register tagged with the requester id.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   bus (slave)        requester 0/1 valid/ready/operands/ctrl, ALU drive and
//                      return, response valid/ready/id/result/zero/err
//   gnt_cnt0/1         saturating counts of accepted operations per requester
// Optional feature: define ALU_SHARE_ILLEGAL_OP_EN to flag control codes outside
// {AND, OR, ADD, SUB}; the response then carries rsp_err=1 with zero data.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_share_arbiter_if.slave bus,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  localparam int unsigned CTRL_W = 4;
  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_gnt;
  logic [1:0]        grant_c;
  logic              gnt_any_c;
  logic              gnt_idx_c;
  logic              can_accept_c;
  logic [DATA_W-1:0] sel_a_c;
  logic [DATA_W-1:0] sel_b_c;
  logic [CTRL_W-1:0] sel_ctrl_c;
  logic [DATA_W-1:0] cap_result_c;
  logic              cap_zero_c;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;
  logic              rsp_id_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Grant, next state and ALU operand selection
  always_comb begin
    state_nxt    = state;
    grant_c      = 2'b00;
    can_accept_c = (state == EMPTY) || bus.rsp_ready;
    sel_a_c      = '0;
    sel_b_c      = '0;
    sel_ctrl_c   = CTRL_ADD;

    // No readies while reset is asserted so nothing is consumed and lost.
    if (!reset && can_accept_c) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_c = last_gnt ? 2'b01 : 2'b10;
      end else if (bus.req0_valid) begin
        grant_c = 2'b01;
      end else if (bus.req1_valid) begin
        grant_c = 2'b10;
      end
    end

    if (grant_c[0]) begin
      sel_a_c    = bus.req0_a;
      sel_b_c    = bus.req0_b;
      sel_ctrl_c = bus.req0_ctrl;
    end else if (grant_c[1]) begin
      sel_a_c    = bus.req1_a;
      sel_b_c    = bus.req1_b;
      sel_ctrl_c = bus.req1_ctrl;
    end

    if (grant_c != 2'b00) begin
      state_nxt = FULL;
    end else if ((state == FULL) && bus.rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  assign gnt_any_c      = grant_c[0] | grant_c[1];
  assign gnt_idx_c      = grant_c[1];
  assign bus.req0_ready = grant_c[0];
  assign bus.req1_ready = grant_c[1];
  assign bus.alu_a      = sel_a_c;
  assign bus.alu_b      = sel_b_c;

`ifdef ALU_SHARE_ILLEGAL_OP_EN
  logic illegal_c;
  logic rsp_err_q;

  // Codes outside the supported set are replaced by a harmless ADD
  always_comb begin
    illegal_c = 1'b1;
    case (sel_ctrl_c)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB: illegal_c = 1'b0;
      default: illegal_c = 1'b1;
    endcase
  end

  assign bus.alu_ctrl = illegal_c ? CTRL_ADD : sel_ctrl_c;
  assign cap_result_c = illegal_c ? '0 : bus.alu_result;
  assign cap_zero_c   = illegal_c ? 1'b0 : bus.alu_zero;

  // Error flag travels with the response it belongs to
  always_ff @(posedge clk) begin
    if (reset)          rsp_err_q <= 1'b0;
    else if (gnt_any_c) rsp_err_q <= illegal_c;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.alu_ctrl = sel_ctrl_c;
  assign cap_result_c = bus.alu_result;
  assign cap_zero_c   = bus.alu_zero;
  assign bus.rsp_err  = 1'b0;
`endif

  // Response register, round-robin pointer and grant counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      last_gnt     <= 1'b1;
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
    end else begin
      if (gnt_any_c) begin
        rsp_result_q <= cap_result_c;
        rsp_zero_q   <= cap_zero_c;
        rsp_id_q     <= gnt_idx_c;
        last_gnt     <= gnt_idx_c;
      end
      if (grant_c[0] && (gnt_cnt0 != {CNT_W{1'b1}})) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (grant_c[1] && (gnt_cnt1 != {CNT_W{1'b1}})) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed, table-driven bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_BAD = 4'b1111;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
  );

  always #5 clk = ~clk;

  // Reference ALU: zero flag only meaningful for SUB; unknown codes give a^b
  always_comb begin
    case (bus.alu_ctrl)
      C_AND:   bus.alu_result = bus.alu_a & bus.alu_b;
      C_OR:    bus.alu_result = bus.alu_a | bus.alu_b;
      C_ADD:   bus.alu_result = bus.alu_a + bus.alu_b;
      C_SUB:   bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = bus.alu_a ^ bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_ctrl == C_SUB) && (bus.alu_a == bus.alu_b);
  end

  typedef struct {
    logic        rst;
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  c0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  c1;
    logic        rr;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_valid;
    logic        e_id;
    logic [31:0] e_res;
    logic        e_zero;
    logic [1:0]  e_cnt0;
    logic [1:0]  e_cnt1;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] c0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [3:0] c1, input logic rr);
    reset         = rst;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1;
    bus.rsp_ready  = rr;
  endtask

  function automatic vec_t mk(input logic rst, input logic v0, input logic [31:0] a0,
                              input logic [31:0] b0, input logic [3:0] c0, input logic v1,
                              input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                              input logic rr, input logic r0, input logic r1, input logic val,
                              input logic id, input logic [31:0] res, input logic z,
                              input logic [1:0] n0, input logic [1:0] n1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr = rr;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_valid = val; v.e_id = id;
    v.e_res = res; v.e_zero = z; v.e_cnt0 = n0; v.e_cnt1 = n1;
    return v;
  endfunction

  initial begin
    // Expected registered outputs are those seen just after the row's clock edge
    vecs[0]  = mk(1, 1, 5, 3, C_ADD, 0, 0, 0, C_ADD, 1,       0, 0, 0, 0, 32'h0,  0, 0, 0);
    vecs[1]  = mk(0, 1, 5, 3, C_ADD, 0, 0, 0, C_ADD, 1,       1, 0, 1, 0, 32'h8,  0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, C_ADD, 0, 0, 0, C_ADD, 1,       0, 0, 0, 0, 32'h8,  0, 1, 0);
    vecs[3]  = mk(1, 0, 0, 0, C_ADD, 0, 0, 0, C_ADD, 1,       0, 0, 0, 0, 32'h0,  0, 0, 0);
    vecs[4]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 1, 0, 1, 0, 32'h0,  1, 1, 0);
    vecs[5]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 0, 1, 1, 1, 32'hFF, 0, 1, 1);
    vecs[6]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 1, 0, 1, 0, 32'h0,  1, 2, 1);
    vecs[7]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 0, 1, 1, 1, 32'hFF, 0, 2, 2);
    vecs[8]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 0, 0, 0, 1, 1, 32'hFF, 0, 2, 2);
    vecs[9]  = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 0, 0, 0, 1, 1, 32'hFF, 0, 2, 2);
    vecs[10] = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 0, 0, 0, 1, 1, 32'hFF, 0, 2, 2);
    vecs[11] = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 1, 0, 1, 0, 32'h0,  1, 3, 2);
    vecs[12] = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 0, 0, 0, 1, 0, 32'h0,  1, 3, 2);
    vecs[13] = mk(1, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0);
    vecs[14] = mk(0, 1, 7, 7, C_SUB, 1, 32'hF0, 32'h0F, C_OR, 1, 1, 0, 1, 0, 32'h0,  1, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, C_ADD, 1, 2, 3, C_ADD, 1,       0, 1, 1, 1, 32'h5,  0, 1, 1);
    vecs[16] = mk(0, 0, 0, 0, C_ADD, 1, 2, 3, C_ADD, 1,       0, 1, 1, 1, 32'h5,  0, 1, 2);
    vecs[17] = mk(0, 0, 0, 0, C_ADD, 1, 2, 3, C_ADD, 1,       0, 1, 1, 1, 32'h5,  0, 1, 3);
    vecs[18] = mk(0, 0, 0, 0, C_ADD, 1, 2, 3, C_ADD, 1,       0, 1, 1, 1, 32'h5,  0, 1, 3);
    vecs[19] = mk(0, 0, 0, 0, C_ADD, 1, 2, 3, C_ADD, 1,       0, 1, 1, 1, 32'h5,  0, 1, 3);
    vecs[20] = mk(0, 1, 32'hC, 32'hA, C_AND, 0, 0, 0, C_ADD, 1, 1, 0, 1, 0, 32'h8, 0, 2, 3);
    vecs[21] = mk(0, 0, 0, 0, C_ADD, 0, 0, 0, C_ADD, 0,       0, 0, 1, 0, 32'h8,  0, 2, 3);
    vecs[22] = mk(0, 0, 0, 0, C_ADD, 0, 0, 0, C_ADD, 1,       0, 0, 0, 0, 32'h8,  0, 2, 3);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
            vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rr);
      #2;
      chk("req0_ready", i, 32'(bus.req0_ready), 32'(vecs[i].e_rdy0));
      chk("req1_ready", i, 32'(bus.req1_ready), 32'(vecs[i].e_rdy1));
      @(posedge clk); #1;
      chk("rsp_valid",  i, 32'(bus.rsp_valid),  32'(vecs[i].e_valid));
      chk("rsp_id",     i, 32'(bus.rsp_id),     32'(vecs[i].e_id));
      chk("rsp_result", i, bus.rsp_result,      vecs[i].e_res);
      chk("rsp_zero",   i, 32'(bus.rsp_zero),   32'(vecs[i].e_zero));
      chk("rsp_err",    i, 32'(bus.rsp_err),    32'h0);
      chk("gnt_cnt0",   i, 32'(gnt_cnt0),       32'(vecs[i].e_cnt0));
      chk("gnt_cnt1",   i, 32'(gnt_cnt1),       32'(vecs[i].e_cnt1));
    end

    // Idle ALU drive is a harmless ADD of zeros
    drive(0, 0, 0, 0, C_AND, 0, 0, 0, C_AND, 1);
    #2;
    chk("idle_alu_a",    100, bus.alu_a,           32'h0);
    chk("idle_alu_b",    100, bus.alu_b,           32'h0);
    chk("idle_alu_ctrl", 100, 32'(bus.alu_ctrl),   32'(C_ADD));
    @(posedge clk); #1;

    // Requester 1 operands reach the ALU when it holds the grant
    drive(0, 0, 0, 0, C_ADD, 1, 32'h11, 32'h22, C_SUB, 1);
    #2;
    chk("r1_alu_a",    101, bus.alu_a,         32'h11);
    chk("r1_alu_b",    101, bus.alu_b,         32'h22);
    chk("r1_alu_ctrl", 101, 32'(bus.alu_ctrl), 32'(C_SUB));
    @(posedge clk); #1;
    chk("r1_result",   101, bus.rsp_result,    32'hFFFF_FFEF);
    chk("r1_id",       101, 32'(bus.rsp_id),   32'h1);
    chk("r1_cnt1_sat", 101, 32'(gnt_cnt1),     32'h3);

    // Undefined control code from requester 0
    drive(0, 1, 1, 1, C_BAD, 0, 0, 0, C_ADD, 1);
    #2;
    chk("bad_ready", 102, 32'(bus.req0_ready), 32'h1);
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    chk("bad_alu_ctrl", 102, 32'(bus.alu_ctrl), 32'(C_ADD));
`else
    chk("bad_alu_ctrl", 102, 32'(bus.alu_ctrl), 32'(C_BAD));
`endif
    @(posedge clk); #1;
`ifdef ALU_SHARE_ILLEGAL_OP_EN
    chk("bad_rsp_err", 102, 32'(bus.rsp_err), 32'h1);
`else
    chk("bad_rsp_err", 102, 32'(bus.rsp_err), 32'h0);
`endif
    chk("bad_rsp_result", 102, bus.rsp_result,     32'h0);
    chk("bad_rsp_zero",   102, 32'(bus.rsp_zero),  32'h0);
    chk("bad_rsp_valid",  102, 32'(bus.rsp_valid), 32'h1);
    chk("bad_cnt0",       102, 32'(gnt_cnt0),      32'h3);

    drive(0, 0, 0, 0, C_ADD, 0, 0, 0, C_ADD, 1);
    @(posedge clk); #1;
    chk("drain_valid", 103, 32'(bus.rsp_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
